// File: rtl/multi_sel_dec_pkg.sv
// Shared types and constants for the multiply-stream decoder.
// Contents: frame-phase state enum, operand/product widths, phase multipliers.
package multi_sel_dec_pkg;

   localparam int DATA_W = 8;
   localparam int PROD_W = 11;

   localparam int MUL_X1 = 1;
   localparam int MUL_X3 = 3;
   localparam int MUL_X7 = 7;
   localparam int MUL_X8 = 8;

   typedef enum logic [2:0] {
      HUNT,
      PH3,
      PH7,
      PH8,
      CHK
   } state_e;

endpackage

// File: rtl/multi_sel_dec_exp.sv
// Expected-product generator for the multiply-stream decoder.
// Ports:
//   op   : captured 8-bit operand
//   exp3 : 3*op, 11 bits
//   exp7 : 7*op, 11 bits
//   exp8 : 8*op, 11 bits
// Pure combinational shift-add; the widened operand keeps every result exact.
module multi_sel_exp
   import multi_sel_dec_pkg::*;
(
   input  logic [DATA_W-1:0] op,
   output logic [PROD_W-1:0] exp3,
   output logic [PROD_W-1:0] exp7,
   output logic [PROD_W-1:0] exp8
);

   logic [PROD_W-1:0] op_w;

   always_comb begin
      op_w = PROD_W'(op);
      exp8 = op_w << 3;
      exp3 = (op_w << 1) + op_w;
      exp7 = (op_w << 3) - op_w;
   end

endmodule

// File: rtl/multi_sel_dec.sv
// Receive-side decoder/checker for the 4-phase constant-multiply stream
// (x1, x3, x7, x8; one phase per clock; in_grant marks the x1 phase).
// Ports:
//   clk      : system clock, posedge
//   rst      : asynchronous active-low reset
//   in_grant : frame-start marker
//   din      : 11-bit product stream
//   d_out    : recovered operand, held until the next d_valid
//   d_valid  : one-cycle pulse, good frame decoded
//   err      : one-cycle pulse, frame rejected (mismatch or early grant)
//   locked   : aligned to the frame cadence
//   err_cnt  : saturating count of err pulses
// Build option: MULTI_SEL_DEC_ERRCNT_EN enables the error counter; when it
// is undefined err_cnt is tied to zero.
module multi_sel_dec
   import multi_sel_dec_pkg::*;
#(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_grant,
   input  logic [PROD_W-1:0]    din,
   output logic [DATA_W-1:0]    d_out,
   output logic                 d_valid,
   output logic                 err,
   output logic                 locked,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   op_q, op_d;
   logic                bad_q, bad_d;
   logic [DATA_W-1:0]   d_out_q, d_out_d;
   logic                d_valid_q, d_valid_d;
   logic                err_q, err_d;
   logic                locked_q, locked_d;

   logic [PROD_W-1:0]   exp3, exp7, exp8;
   logic                phase_bad;
   logic                mid_frame;

   multi_sel_exp u_exp (
      .op   (op_q),
      .exp3 (exp3),
      .exp7 (exp7),
      .exp8 (exp8)
   );

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= HUNT;
         op_q      <= '0;
         bad_q     <= 1'b0;
         d_out_q   <= '0;
         d_valid_q <= 1'b0;
         err_q     <= 1'b0;
         locked_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         bad_q     <= bad_d;
         d_out_q   <= d_out_d;
         d_valid_q <= d_valid_d;
         err_q     <= err_d;
         locked_q  <= locked_d;
      end
   end

   // Next state: a grant always restarts the frame, whatever the state
   always_comb begin
      state_d = state_q;
      if (in_grant) begin
         state_d = PH3;
      end else begin
         case (state_q)
            HUNT:    state_d = HUNT;
            PH3:     state_d = PH7;
            PH7:     state_d = PH8;
            PH8:     state_d = CHK;
            CHK:     state_d = HUNT;
            default: state_d = HUNT;
         endcase
      end
   end

   // Per-phase product check against the captured operand
   always_comb begin
      case (state_q)
         PH3:     phase_bad = (din != exp3);
         PH7:     phase_bad = (din != exp7);
         PH8:     phase_bad = (din != exp8);
         default: phase_bad = 1'b0;
      endcase
      mid_frame = (state_q == PH3) || (state_q == PH7) || (state_q == PH8);
   end

   // Output/datapath next values. The frame verdict is formed in PH8 so the
   // pulses land in CHK, concurrently with any new capture from a grant there.
   always_comb begin
      op_d      = op_q;
      bad_d     = bad_q;
      d_out_d   = d_out_q;
      d_valid_d = 1'b0;
      err_d     = 1'b0;
      locked_d  = locked_q;
      if (in_grant) begin
         op_d  = din[DATA_W-1:0];
         bad_d = |din[PROD_W-1:DATA_W];
         if (mid_frame) begin
            err_d    = 1'b1;
            locked_d = 1'b0;
         end
      end else begin
         case (state_q)
            PH3, PH7: bad_d = bad_q | phase_bad;
            PH8: begin
               if (bad_q || phase_bad) begin
                  err_d    = 1'b1;
                  locked_d = 1'b0;
               end else begin
                  d_valid_d = 1'b1;
                  d_out_d   = op_q;
                  locked_d  = 1'b1;
               end
            end
            CHK:     locked_d = 1'b0;
            default: ;
         endcase
      end
   end

   assign d_out   = d_out_q;
   assign d_valid = d_valid_q;
   assign err     = err_q;
   assign locked  = locked_q;

`ifdef MULTI_SEL_DEC_ERRCNT_EN
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   // Counts alongside the err flop so err_cnt already includes a pulse
   // during the cycle that pulse is visible.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_d && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_multi_sel_dec.sv
// Bench for multi_sel_dec: directed frames, a frame-level reference model
// compared every cycle, and literal expectations at the key points.
// A second instance with a 2-bit counter exercises saturation.
module tb_multi_sel_dec;
   import multi_sel_dec_pkg::*;

   logic        clk;
   logic        rst;
   logic        in_grant;
   logic [10:0] din;
   logic [7:0]  d_out, d_out2;
   logic        d_valid, d_valid2;
   logic        err, err2;
   logic        locked, locked2;
   logic [7:0]  err_cnt;
   logic [1:0]  err_cnt2;

   int n_checks = 0;
   int n_fail   = 0;

   multi_sel_dec #(.ERR_CNT_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_grant (in_grant),
      .din      (din),
      .d_out    (d_out),
      .d_valid  (d_valid),
      .err      (err),
      .locked   (locked),
      .err_cnt  (err_cnt)
   );

   multi_sel_dec #(.ERR_CNT_W(2)) dut2 (
      .clk      (clk),
      .rst      (rst),
      .in_grant (in_grant),
      .din      (din),
      .d_out    (d_out2),
      .d_valid  (d_valid2),
      .err      (err2),
      .locked   (locked2),
      .err_cnt  (err_cnt2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (frame-level) ----------------
   int          mul[4] = '{MUL_X1, MUL_X3, MUL_X7, MUL_X8};
   logic [10:0] fr[4];
   int          n_got = 0;    // samples collected in current frame (0 = none)
   int          m_dout = 0;
   int          m_valid = 0;
   int          m_err = 0;
   int          m_locked = 0;
   int          m_cnt8 = 0;
   int          m_cnt2 = 0;

   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            n_got = 0; m_dout = 0; m_valid = 0; m_err = 0;
            m_locked = 0; m_cnt8 = 0; m_cnt2 = 0;
         end else begin
            m_valid = 0;
            m_err   = 0;
            if (in_grant) begin
               if (n_got >= 1 && n_got <= 3) begin
                  m_err    = 1;
                  m_locked = 0;
               end
               fr[0] = din;
               n_got = 1;
            end else if (n_got >= 1 && n_got <= 3) begin
               fr[n_got] = din;
               n_got++;
               if (n_got == 4) begin
                  int  op;
                  bit  good;
                  op   = int'(fr[0]) % 256;
                  good = (int'(fr[0]) < 256);
                  for (int k = 1; k < 4; k++)
                     if (int'(fr[k]) != mul[k] * op) good = 0;
                  if (good) begin
                     m_valid  = 1;
                     m_dout   = op;
                     m_locked = 1;
                  end else begin
                     m_err    = 1;
                     m_locked = 0;
                  end
               end
            end else if (n_got == 4) begin
               n_got    = 0;
               m_locked = 0;
            end
            if (m_err == 1) begin
               if (m_cnt8 < 255) m_cnt8++;
               if (m_cnt2 < 3)   m_cnt2++;
            end
         end
      end
   end

`ifdef MULTI_SEL_DEC_ERRCNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   // Every-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         check("d_out",    d_out,    m_dout);
         check("d_valid",  d_valid,  m_valid);
         check("err",      err,      m_err);
         check("locked",   locked,   m_locked);
         check("err_cnt",  err_cnt,  CNT_EN ? m_cnt8 : 0);
         check("err_cnt2", err_cnt2, CNT_EN ? m_cnt2 : 0);
         check("d_out2",   d_out2,   m_dout);
         check("locked2",  locked2,  m_locked);
      end
   end

   task automatic cyc(input logic g, input logic [10:0] d);
      @(negedge clk);
      in_grant = g;
      din      = d;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      rst = 1'b0; in_grant = 1'b0; din = '0;
      cyc(0, 0); cyc(0, 0);
      check("rst_d_out", d_out, 0);
      check("rst_locked", locked, 0);
      check("rst_cnt", err_cnt, 0);
      rst = 1'b1;

      // single good frame 0x05
      cyc(1, 5); cyc(0, 15); cyc(0, 35); cyc(0, 40);
      cyc(0, 0);
      check("f05_valid", d_valid, 1);
      check("f05_dout", d_out, 8'h05);
      check("f05_locked", locked, 1);
      check("f05_err", err, 0);

      // back-to-back 0xFF then 0x80
      cyc(1, 255); cyc(0, 765); cyc(0, 1785); cyc(0, 2040);
      cyc(1, 128);
      check("fff_valid", d_valid, 1);
      check("fff_dout", d_out, 8'hFF);
      cyc(0, 384); cyc(0, 896); cyc(0, 1024);
      cyc(0, 0);
      check("f80_valid", d_valid, 1);
      check("f80_dout", d_out, 8'h80);
      check("f80_locked", locked, 1);
      // missing grant: locked drops next cycle, din ignored
      cyc(0, 7);
      check("hunt_locked", locked, 0);
      cyc(0, 50); cyc(0, 99);
      check("hunt_valid", d_valid, 0);
      check("hunt_cnt", err_cnt, 0);

      // good 0x03 followed by corrupt 0x05 (x7 phase = 36)
      cyc(1, 3); cyc(0, 9); cyc(0, 21); cyc(0, 24);
      cyc(1, 5);
      check("f03_locked", locked, 1);
      cyc(0, 15); cyc(0, 36); cyc(0, 40);
      cyc(0, 0);
      check("bad_err", err, 1);
      check("bad_valid", d_valid, 0);
      check("bad_dout_hold", d_out, 8'h03);
      check("bad_locked", locked, 0);
      check("bad_cnt", err_cnt, CNT_EN ? 1 : 0);

      // early grant at T+2
      cyc(1, 5); cyc(0, 15); cyc(1, 9);
      cyc(0, 27);
      check("early_err", err, 1);
      check("early_valid", d_valid, 0);
      cyc(0, 63); cyc(0, 72);
      cyc(0, 0);
      check("early_new_valid", d_valid, 1);
      check("early_new_dout", d_out, 8'h09);
      check("early_cnt", err_cnt, CNT_EN ? 2 : 0);

      // five bad frames back-to-back (high bits set in x1 phase)
      for (int i = 0; i < 5; i++) begin
         cyc(1, 11'h100 | 11'(i));
         cyc(0, 11'(3 * i)); cyc(0, 11'(7 * i)); cyc(0, 11'(8 * i));
      end
      cyc(0, 0);
      check("sat_err", err, 1);
      check("sat_cnt8", err_cnt, CNT_EN ? 7 : 0);
      check("sat_cnt2", err_cnt2, CNT_EN ? 3 : 0);
      cyc(0, 0);

      // reset in the middle of a frame
      cyc(1, 6); cyc(0, 18); cyc(0, 42); cyc(0, 48);
      cyc(1, 10);
      check("pre_rst_locked", locked, 1);
      cyc(0, 30); cyc(0, 70);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_dout", d_out, 0);
      check("mid_rst_locked", locked, 0);
      check("mid_rst_valid", d_valid, 0);
      check("mid_rst_cnt", err_cnt, 0);
      cyc(0, 80);
      rst = 1'b1;
      cyc(0, 0); cyc(0, 0); cyc(0, 0);
      check("post_rst_err", err, 0);
      check("post_rst_valid", d_valid, 0);

      // recovery with a fresh good frame
      cyc(1, 1); cyc(0, 3); cyc(0, 7); cyc(0, 8);
      cyc(0, 0);
      check("rec_valid", d_valid, 1);
      check("rec_dout", d_out, 8'h01);
      cyc(0, 0); cyc(0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_sel_dec.md
Name: multi_sel_dec

Overview:
- Receive-side decoder for the 4-phase constant-multiply stream (operand ×1, ×3, ×7, ×8, one phase per clock, frame start marked by a grant pulse).
- Recovers the 8-bit operand, checks all four phases for consistency, and flags malformed frames.
- Sits downstream of the multiply-sequencer in the same datapath, as its checker/consumer.

Parameters:
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  asynchronous active-low reset.
- in_grant  input  1  frame-start marker; high in the ×1 phase.
- din  input  11  product stream.
- d_out  output  8  recovered operand, held until the next d_valid.
- d_valid  output  1  one-cycle pulse: d_out updated from a good frame.
- err  output  1  one-cycle pulse: a frame was rejected.
- locked  output  1  decoder is aligned to the frame cadence.
- err_cnt  output  ERR_CNT_W  saturating count of err pulses.

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous, active-low.
- Reset values: d_out=0, d_valid=0, err=0, locked=0, err_cnt=0, state=HUNT, internal operand and bad-flag = 0.
- States: HUNT, PH3, PH7, PH8, CHK. Frame start cycle is T; the phases are:
  - T: ×1 phase.
  - T+1: PH3.
  - T+2: PH7.
  - T+3: PH8.
  - T+4: CHK.
- Frame start (any state, in_grant=1):
  - Capture op=din[7:0].
  - Set bad=(din[10:8]!=0).
  - Next state is PH3.
- Phase checks:
  - PH3: compare din against 3·op.
  - PH7: compare din against 7·op.
  - PH8: compare din against 8·op.
  - All compares are on the full 11 bits, with zero-extended exact arithmetic (max 8·255=2040, no overflow).
  - A mismatch sets bad.
- End of frame (registered, visible at T+4):
  - PH8 → CHK.
  - bad=0: d_valid=1, d_out=op, locked=1.
  - bad=1: err=1, locked=0, d_out unchanged.
- CHK state:
  - in_grant=1: new frame start (back-to-back frames every 4 cycles are the normal cadence).
  - in_grant=0: go to HUNT; locked is cleared the following cycle.
- HUNT: din ignored until in_grant=1.
- Early grant (in_grant=1 while in PH3/PH7/PH8):
  - The current frame is aborted.
  - err pulses next cycle, locked clears.
  - The grant cycle is taken as ×1 of a new frame.
  - No d_valid is issued for the aborted frame.
- Simultaneous events: CHK result and a new frame start in the same cycle are both honoured; the result pulses come from the old frame, the capture from the new one.
- err_cnt: increments by 1 on each err pulse and saturates at all-ones.
- Reset mid-frame: all state is discarded immediately (async); no pulses are issued after release until a full good frame completes.
- Latency: d_valid is asserted 4 cycles after the in_grant cycle.

Optional Feature:
- MULTI_SEL_DEC_ERRCNT_EN
  - Defined: err_cnt counter is implemented as above.
  - Undefined: counter logic is removed and err_cnt is tied to 0; the port remains.

Decomposition:
- Package multi_sel_dec_pkg:
  - State enum (HUNT, PH3, PH7, PH8, CHK).
  - Localparams DATA_W=8, PROD_W=11.
  - Multiply constants 1, 3, 7, 8.
- One sub-module multi_sel_exp: combinational; op → expected 3·op, 7·op, 8·op via shift-add (no multipliers). The FSM/checker stays in the top module.

Test Plan:
- Single frame for d=0x05: grant with din=5, then 15, 35, 40 → d_valid at T+4 with d_out=0x05, locked=1, err=0.
- Back-to-back frames for d=0xFF then 0x80: (255, 765, 1785, 2040) then (128, 384, 896, 1024) → d_valid at T+4 (0xFF) and T+8 (0x80), locked stays 1.
- Corruption: 0x05 frame with ×7 phase=36 → err at T+4, no d_valid, d_out keeps its old value, err_cnt=1, locked=0.
- Early grant: grant at T+2 → err at T+3; the new frame from T+2 completes normally with d_valid at T+6.
- Missing grant after a good frame → locked drops at T+5, later din values are ignored, err_cnt is unchanged.
- Reset asserted at T+2 of a frame → all outputs 0 immediately, no pulses afterwards. With ERR_CNT_W=2 and 5 bad frames → err_cnt saturates at 3. With the macro undefined → err_cnt stays 0.
